// File: rtl/debug_access_ctrl_pkg.sv
// rtl/debug_access_ctrl_pkg.sv - shared encodings for the debug access controller
package debug_access_ctrl_pkg;

  localparam logic [1:0] CMD_READ   = 2'b00;
  localparam logic [1:0] CMD_UNLOCK = 2'b01;
  localparam logic [1:0] CMD_LOCK   = 2'b10;
  localparam logic [1:0] CMD_RSVD   = 2'b11;

  localparam int DEFAULT_SECRET_BASE = 'hC;

  typedef enum logic [1:0] {
    ACC_LOCKED,
    ACC_UNLOCKED,
    ACC_LOCKOUT
  } acc_state_e;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_RD_WAIT,
    REQ_RESP
  } req_state_e;

endpackage

// File: rtl/dbg_lock_fsm.sv
// rtl/dbg_lock_fsm.sv - access state, fail counter, lockout and idle timers
// eff_* report the state after this cycle's timer expiries, so requests see it first.
module dbg_lock_fsm
  import debug_access_ctrl_pkg::*;
#(
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int IDLE_TIMEOUT   = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic unlock_ok,
  input  logic unlock_fail,
  input  logic lock,
  input  logic activity,
  output logic unlocked,
  output logic lockout,
  output logic eff_unlocked,
  output logic eff_lockout
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int LT_W   = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IT_W   = $clog2(IDLE_TIMEOUT + 1);

  acc_state_e        state;
  logic [FAIL_W-1:0] fail_cnt;
  logic [FAIL_W-1:0] fail_base;
  logic [LT_W-1:0]   lock_tmr;
  logic [IT_W-1:0]   idle_tmr;
  logic              lockout_done;
  logic              idle_expire;

  assign lockout_done = (state == ACC_LOCKOUT) && (lock_tmr >= LT_W'(LOCKOUT_CYCLES - 1));
  assign idle_expire  = (state == ACC_UNLOCKED) && (idle_tmr >= IT_W'(IDLE_TIMEOUT - 1));
  assign eff_unlocked = (state == ACC_UNLOCKED) && !idle_expire;
  assign eff_lockout  = (state == ACC_LOCKOUT) && !lockout_done;
  assign unlocked     = (state == ACC_UNLOCKED);
  assign lockout      = (state == ACC_LOCKOUT);
  assign fail_base    = lockout_done ? '0 : fail_cnt;

  // Timers only advance in the branch where they have not expired, so they cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC_LOCKED;
      fail_cnt <= '0;
      lock_tmr <= '0;
      idle_tmr <= '0;
    end else begin
      fail_cnt <= fail_base;
      if (unlock_ok) begin
        state    <= ACC_UNLOCKED;
        fail_cnt <= '0;
        idle_tmr <= '0;
      end else if (unlock_fail) begin
        if (fail_base >= FAIL_W'(MAX_FAIL - 1)) begin
          state    <= ACC_LOCKOUT;
          fail_cnt <= FAIL_W'(MAX_FAIL);
          lock_tmr <= '0;
        end else begin
          state    <= ACC_LOCKED;
          fail_cnt <= fail_base + 1'b1;
        end
      end else if (lock || idle_expire || lockout_done) begin
        state <= ACC_LOCKED;
      end else begin
        if (state == ACC_LOCKOUT) lock_tmr <= lock_tmr + 1'b1;
        if (state == ACC_UNLOCKED) idle_tmr <= activity ? '0 : idle_tmr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_access_ctrl.sv
// rtl/debug_access_ctrl.sv - debug-port gatekeeper and request sequencer
// rf_rd_en is issued in the acceptance cycle so read data lands in RD_WAIT.
module debug_access_ctrl
  import debug_access_ctrl_pkg::*;
#(
  parameter int                ADDR_W         = 4,
  parameter logic [ADDR_W-1:0] SECRET_BASE    = ADDR_W'(DEFAULT_SECRET_BASE),
  parameter int                MAX_FAIL       = 3,
  parameter int                LOCKOUT_CYCLES = 1024,
  parameter int                IDLE_TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_req,
  input  logic [1:0]        dbg_cmd,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [31:0]       unlock_key,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [31:0]       rf_rdata,
  output logic              unlocked,
  output logic              lockout
);

  req_state_e req_state;
  logic accept, key_match, secret, rd_auth, unlock_try;
  logic unlock_ok, unlock_fail, lock_req, req_err;
  logic eff_unlocked, eff_lockout;

  assign accept      = (req_state == REQ_IDLE) && dbg_req && !rst;
  assign key_match   = (dbg_wdata == unlock_key);
  assign secret      = (dbg_addr >= SECRET_BASE);
  assign rd_auth     = accept && (dbg_cmd == CMD_READ) && eff_unlocked && !secret;
  assign unlock_try  = accept && (dbg_cmd == CMD_UNLOCK) && !eff_unlocked && !eff_lockout;
  assign unlock_ok   = unlock_try && key_match;
  assign unlock_fail = unlock_try && !key_match;
  assign lock_req    = accept && (dbg_cmd == CMD_LOCK) && eff_unlocked;
  assign rf_rd_en    = rd_auth;
  assign rf_addr     = rd_auth ? dbg_addr : '0;

  always_comb begin
    req_err = 1'b0;
    if (eff_lockout) begin
      req_err = 1'b1;
    end else begin
      case (dbg_cmd)
        CMD_READ:   req_err = !eff_unlocked || secret;
        CMD_UNLOCK: req_err = !eff_unlocked && !key_match;
        CMD_LOCK:   req_err = 1'b0;
        default:    req_err = 1'b1;
      endcase
    end
  end

  dbg_lock_fsm #(
    .MAX_FAIL       (MAX_FAIL),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .IDLE_TIMEOUT   (IDLE_TIMEOUT)
  ) u_lock_fsm (
    .clk          (clk),
    .rst          (rst),
    .unlock_ok    (unlock_ok),
    .unlock_fail  (unlock_fail),
    .lock         (lock_req),
    .activity     (accept),
    .unlocked     (unlocked),
    .lockout      (lockout),
    .eff_unlocked (eff_unlocked),
    .eff_lockout  (eff_lockout)
  );

  // Response outputs default to zero every cycle so read data never lingers past its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_state <= REQ_IDLE;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      dbg_err   <= 1'b0;
    end else begin
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      dbg_err   <= 1'b0;
      case (req_state)
        REQ_IDLE: begin
          if (rd_auth) begin
            req_state <= REQ_RD_WAIT;
          end else if (accept) begin
            req_state <= REQ_RESP;
            dbg_ack   <= 1'b1;
            dbg_err   <= req_err;
          end
        end
        REQ_RD_WAIT: begin
          req_state <= REQ_RESP;
          dbg_ack   <= 1'b1;
          dbg_rdata <= rf_rdata;
        end
        default: req_state <= REQ_IDLE;
      endcase
    end
  end

endmodule
